// File: rtl/fetch_exec_sequencer_if.sv
// Fetch/execute sequencer bus: fetch-register and ROM inputs, ALU flags,
// PC and fetch-register controls, and the execute valid/ready handshake.
// master = sequencer side, slave = datapath side.
interface fetch_exec_sequencer_if;
  logic [3:0]  instr;
  logic [3:0]  operand;
  logic [7:0]  program_byte;
  logic        carry;
  logic        zero;
  logic        exec_ready;
  logic        resume;
  logic        pc_inc;
  logic        pc_load;
  logic [11:0] pc_value;
  logic        fetch_en;
  logic        exec_valid;
  logic [7:0]  exec_imm;
  logic [1:0]  state;
  logic [15:0] instr_count;

  modport master (
    input  instr, operand, program_byte, carry, zero, exec_ready, resume,
    output pc_inc, pc_load, pc_value, fetch_en, exec_valid, exec_imm,
           state, instr_count
  );

  modport slave (
    output instr, operand, program_byte, carry, zero, exec_ready, resume,
    input  pc_inc, pc_load, pc_value, fetch_en, exec_valid, exec_imm,
           state, instr_count
  );
endinterface

// File: rtl/fetch_exec_sequencer.sv
// Fetch/execute control FSM for a 12-bit-PC program fetch datapath.
// FETCH latches the byte at PC and increments PC; EXEC presents the decoded
// instruction (plus the second byte for two-byte opcodes 0x0-0x7) to the
// execute datapath and, on acceptance, resolves jumps or skips the second byte.
// Optional feature macro: FETCH_SEQ_HALT_EN (HALT_OP parks the FSM in HALT
// until resume). With the macro undefined HALT_OP is an ordinary one-byte op.
module fetch_exec_sequencer #(
  parameter logic [3:0] JMP_OP  = 4'h0,
  parameter logic [3:0] JC_OP   = 4'h1,
  parameter logic [3:0] JNC_OP  = 4'h2,
  parameter logic [3:0] JZ_OP   = 4'h3,
  parameter logic [3:0] JNZ_OP  = 4'h4,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_exec_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] count_r;
  logic [15:0] count_nxt_s;
  logic        pc_inc_s;
  logic        pc_load_s;
  logic [11:0] pc_value_s;
  logic        fetch_en_s;
  logic        exec_valid_s;
  logic [7:0]  exec_imm_s;
  logic        two_byte_s;
  logic        taken_s;

  // Jump resolution; non-jump opcodes never take.
  function automatic logic jump_taken(input logic [3:0] op,
                                      input logic c, input logic z);
    logic t;
    case (op)
      JMP_OP:  t = 1'b1;
      JC_OP:   t = c;
      JNC_OP:  t = ~c;
      JZ_OP:   t = z;
      JNZ_OP:  t = ~z;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign two_byte_s = ~bus.instr[3];
  assign taken_s    = two_byte_s & jump_taken(bus.instr, bus.carry, bus.zero);

`ifndef FETCH_SEQ_HALT_EN
  logic unused_halt_s;
  assign unused_halt_s = ^{bus.resume, HALT_OP};
`endif

  // State register and retired-instruction counter, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
      count_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Next-state and control outputs; everything quiet while reset is high.
  always_comb begin
    state_nxt_s  = state_r;
    count_nxt_s  = count_r;
    pc_inc_s     = 1'b0;
    pc_load_s    = 1'b0;
    pc_value_s   = 12'd0;
    fetch_en_s   = 1'b0;
    exec_valid_s = 1'b0;
    exec_imm_s   = 8'd0;
    if (reset) begin
      state_nxt_s = ST_FETCH;
      count_nxt_s = 16'd0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          fetch_en_s  = 1'b1;
          pc_inc_s    = 1'b1;
          state_nxt_s = ST_EXEC;
        end
        ST_EXEC: begin
          exec_valid_s = 1'b1;
          if (two_byte_s) begin
            exec_imm_s = bus.program_byte;
          end else begin
            exec_imm_s = 8'd0;
          end
          if (bus.exec_ready) begin
            count_nxt_s = count_r + 16'd1;
            state_nxt_s = ST_FETCH;
            if (two_byte_s) begin
              if (taken_s) begin
                pc_load_s  = 1'b1;
                pc_value_s = {bus.operand, bus.program_byte};
              end else begin
                // Skip over the second byte.
                pc_inc_s = 1'b1;
              end
            end else begin
`ifdef FETCH_SEQ_HALT_EN
              if (bus.instr == HALT_OP) begin
                state_nxt_s = ST_HALT;
              end else begin
                state_nxt_s = ST_FETCH;
              end
`else
              state_nxt_s = ST_FETCH;
`endif
            end
          end else begin
            // Stall: hold the instruction, no PC or fetch activity.
            state_nxt_s = ST_EXEC;
          end
        end
        ST_HALT: begin
`ifdef FETCH_SEQ_HALT_EN
          if (bus.resume) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_HALT;
          end
`else
          state_nxt_s = ST_FETCH;
`endif
        end
        default: begin
          state_nxt_s = ST_FETCH;
        end
      endcase
    end
  end

  assign bus.pc_inc      = pc_inc_s;
  assign bus.pc_load     = pc_load_s;
  assign bus.pc_value    = pc_value_s;
  assign bus.fetch_en    = fetch_en_s;
  assign bus.exec_valid  = exec_valid_s;
  assign bus.exec_imm    = exec_imm_s;
  assign bus.state       = state_r;
  assign bus.instr_count = count_r;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Bench for fetch_exec_sequencer: models the PC/ROM/fetch-register datapath
// around the DUT and checks every instruction against an instruction-level
// reference model (next PC, immediate, jump decision, retired count).
module tb_fetch_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom [0:4095];
  logic [11:0] dp_pc;
  logic [7:0]  fr;
  logic [11:0] mdl_pc;
  logic [15:0] mdl_count;
  int          checks = 0;
  int          failures = 0;

  fetch_exec_sequencer_if bus();

  fetch_exec_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.instr        = fr[7:4];
  assign bus.operand      = fr[3:0];
  assign bus.program_byte = rom[dp_pc];

  // Datapath: program counter and fetch register driven by the sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_pc <= 12'd0;
      fr    <= 8'd0;
    end else begin
      if (bus.pc_load) begin
        dp_pc <= bus.pc_value;
      end else if (bus.pc_inc) begin
        dp_pc <= dp_pc + 12'd1;
      end
      if (bus.fetch_en) begin
        fr <= rom[dp_pc];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom(input logic [7:0] val);
    for (int i = 0; i < 4096; i++) rom[i] = val;
  endtask

  // Leaves the bench at posedge+1 of the first FETCH cycle, reset low.
  task automatic do_reset();
    reset = 1'b1;
    bus.exec_ready = 1'b0;
    bus.resume = 1'b0;
    bus.carry = 1'b0;
    bus.zero = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_val("rst_state", bus.state, 32'd0);
    check_val("rst_count", bus.instr_count, 32'd0);
    check_val("rst_ctrl", {bus.fetch_en, bus.pc_inc, bus.pc_load, bus.exec_valid},
              32'd0);
    check_val("rst_pcval", bus.pc_value, 32'd0);
    next_cycle();
    reset = 1'b0;
    mdl_pc = 12'd0;
    mdl_count = 16'd0;
  endtask

  // One whole instruction from its FETCH cycle; returns at posedge+1 of the
  // following FETCH cycle.
  task automatic run_instr(input int stalls, input logic c, input logic z);
    logic [7:0]  b;
    logic [7:0]  sec;
    logic [3:0]  op;
    logic [11:0] nxt_addr;
    logic [11:0] tgt;
    logic        two;
    logic        taken;
    b = rom[mdl_pc];
    op = b[7:4];
    nxt_addr = mdl_pc + 12'd1;
    sec = rom[nxt_addr];
    tgt = {b[3:0], sec};
    two = (op < 4'd8);
    taken = two && ((op == 4'h0) || (op == 4'h1 && c) || (op == 4'h2 && !c) ||
                    (op == 4'h3 && z) || (op == 4'h4 && !z));
    bus.exec_ready = 1'($urandom_range(0, 1));
    bus.carry = 1'($urandom_range(0, 1));
    bus.zero = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_val("fetch_state", bus.state, 32'd0);
    check_val("fetch_en", bus.fetch_en, 32'd1);
    check_val("fetch_pc_inc", bus.pc_inc, 32'd1);
    check_val("fetch_pc_load", bus.pc_load, 32'd0);
    check_val("fetch_valid", bus.exec_valid, 32'd0);
    check_val("fetch_addr", dp_pc, mdl_pc);
    check_val("fetch_count", bus.instr_count, mdl_count);
    for (int i = 0; i < stalls; i++) begin
      next_cycle();
      bus.exec_ready = 1'b0;
      bus.carry = 1'($urandom_range(0, 1));
      bus.zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("stall_state", bus.state, 32'd1);
      check_val("stall_valid", bus.exec_valid, 32'd1);
      check_val("stall_ctrl", {bus.fetch_en, bus.pc_inc, bus.pc_load}, 32'd0);
      check_val("stall_count", bus.instr_count, mdl_count);
    end
    next_cycle();
    bus.exec_ready = 1'b1;
    bus.carry = c;
    bus.zero = z;
    @(negedge clk);
    check_val("exec_state", bus.state, 32'd1);
    check_val("exec_valid", bus.exec_valid, 32'd1);
    check_val("exec_imm", bus.exec_imm, two ? sec : 8'd0);
    check_val("exec_pc_load", bus.pc_load, taken);
    check_val("exec_pc_value", bus.pc_value, taken ? tgt : 12'd0);
    check_val("exec_pc_inc", bus.pc_inc, two && !taken);
    check_val("exec_fetch_en", bus.fetch_en, 32'd0);
    mdl_count = mdl_count + 16'd1;
    mdl_pc = taken ? tgt : (two ? mdl_pc + 12'd2 : nxt_addr);
    next_cycle();
    bus.exec_ready = 1'b0;
`ifdef FETCH_SEQ_HALT_EN
    if (op == 4'hF) begin
      for (int i = 0; i < 10; i++) begin
        bus.resume = (i == 9);
        @(negedge clk);
        check_val("halt_state", bus.state, 32'd2);
        check_val("halt_ctrl", {bus.fetch_en, bus.pc_inc, bus.pc_load,
                                bus.exec_valid}, 32'd0);
        check_val("halt_pc", dp_pc, mdl_pc);
        check_val("halt_count", bus.instr_count, mdl_count);
        next_cycle();
      end
      bus.resume = 1'b0;
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    bus.exec_ready = 1'b0;
    bus.resume = 1'b0;
    bus.carry = 1'b0;
    bus.zero = 1'b0;
    fill_rom(8'h80);

    // Two one-byte instructions back to back.
    rom[0] = 8'h8A;
    rom[1] = 8'h9B;
    do_reset();
    run_instr(0, 1'b0, 1'b0);
    run_instr(0, 1'b0, 1'b0);
    check_val("free_count", bus.instr_count, 32'd2);
    check_val("free_pc", dp_pc, 32'd2);

    // Unconditional jump to 0x123.
    fill_rom(8'h80);
    rom[0] = 8'h01;
    rom[1] = 8'h23;
    do_reset();
    run_instr(0, 1'b0, 1'b0);
    check_val("jmp_target", dp_pc, 32'h123);

    // JZ not taken, then taken.
    fill_rom(8'h80);
    rom[0] = 8'h31;
    rom[1] = 8'h00;
    do_reset();
    run_instr(0, 1'b1, 1'b0);
    check_val("jz_nt_pc", dp_pc, 32'd2);
    do_reset();
    run_instr(0, 1'b0, 1'b1);
    check_val("jz_t_pc", dp_pc, 32'h100);

    // Stalled one-byte instruction.
    fill_rom(8'h80);
    do_reset();
    run_instr(3, 1'b0, 1'b0);
    check_val("stall_done_count", bus.instr_count, 32'd1);

    // Jump to 0xFFF, then a two-byte op whose second byte wraps to 0x000.
    fill_rom(8'h80);
    rom[0] = 8'h0F;
    rom[1] = 8'hFF;
    rom[4095] = 8'h5A;
    do_reset();
    run_instr(0, 1'b0, 1'b0);
    check_val("wrap_jmp_pc", dp_pc, 32'hFFF);
    run_instr(1, 1'b0, 1'b0);
    check_val("wrap_pc", dp_pc, 32'h001);

    // Self-loop jump.
    fill_rom(8'h80);
    rom[16] = 8'h00;
    rom[17] = 8'h10;
    rom[0] = 8'h00;
    rom[1] = 8'h10;
    do_reset();
    run_instr(0, 1'b0, 1'b0);
    run_instr(0, 1'b0, 1'b0);
    check_val("selfloop_pc", dp_pc, 32'h010);

    // Reset during a stalled EXEC aborts the instruction.
    fill_rom(8'h80);
    do_reset();
    run_instr(0, 1'b0, 1'b0);
    @(negedge clk);
    next_cycle();
    bus.exec_ready = 1'b0;
    @(negedge clk);
    check_val("abort_pre_state", bus.state, 32'd1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_ctrl", {bus.fetch_en, bus.pc_inc, bus.pc_load,
                             bus.exec_valid}, 32'd0);
    check_val("abort_pcval", bus.pc_value, 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_val("abort_state", bus.state, 32'd0);
    check_val("abort_count", bus.instr_count, 32'd0);
    next_cycle();

    // HALT opcode (halts only when the feature is built in).
    fill_rom(8'h80);
    rom[0] = 8'hF0;
    do_reset();
    run_instr(0, 1'b0, 1'b0);
    check_val("halt_op_state", bus.state, 32'd0);
    check_val("halt_op_pc", dp_pc, 32'd1);

    // Random programs against the instruction-level model.
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    do_reset();
    for (int n = 0; n < 300; n++) begin
      run_instr(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_exec_sequencer.md
Name: fetch_exec_sequencer

Overview:
- Control FSM that sequences the program-fetch datapath: 12-bit program counter, program ROM, and 8-bit fetch register (instr = byte[7:4], operand = byte[3:0]).
- Drives the PC increment, load and load value, and the fetch-register enable.
- Decodes one- and two-byte instructions and resolves jumps.
- Hands each decoded instruction to the execute datapath through a valid/ready handshake.

Parameters:
- JMP_OP, 4'h0, unconditional jump opcode.
- JC_OP, 4'h1, jump if carry=1.
- JNC_OP, 4'h2, jump if carry=0.
- JZ_OP, 4'h3, jump if zero=1.
- JNZ_OP, 4'h4, jump if zero=0.
- HALT_OP, 4'hF, halt opcode (used only with the optional feature).

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  4  opcode from the fetch register.
- operand  in  4  operand nibble from the fetch register.
- program_byte  in  8  combinational ROM output at the current PC.
- carry  in  1  ALU carry flag, registered externally.
- zero  in  1  ALU zero flag, registered externally.
- exec_ready  in  1  execute datapath accepts the current instruction.
- resume  in  1  leave HALT (optional feature only).
- pc_inc  out  1  PC count enable.
- pc_load  out  1  PC parallel load.
- pc_value  out  12  PC load value.
- fetch_en  out  1  fetch register enable.
- exec_valid  out  1  instruction presented to the datapath.
- exec_imm  out  8  second byte of a two-byte instruction; 0 for one-byte.
- state  out  2  FETCH=0, EXEC=1, HALT=2.
- instr_count  out  16  retired-instruction counter.

Behaviour:
- Reset: synchronous, active-high. While reset is sampled high, next state = FETCH and instr_count = 0. All combinational outputs are 0 while reset is high.
- Two-byte class: instr[3]==0 (0x0–0x7). One-byte class: instr[3]==1.
- FETCH:
  - fetch_en=1, pc_inc=1.
  - Next edge: fetch register latches the byte at PC; PC increments; state moves to EXEC.
  - Always exactly 1 cycle.
- EXEC, one-byte instruction:
  - exec_valid=1, exec_imm=0.
  - When exec_ready=1: instr_count+1, next state FETCH. No PC action.
- EXEC, two-byte instruction:
  - exec_valid=1, exec_imm=program_byte (the byte at the already-incremented PC).
  - Jump opcodes: taken if JMP, or if the flag condition is true (flags sampled this cycle).
  - When exec_ready=1 and jump taken: pc_load=1, pc_value={operand, program_byte}.
  - When exec_ready=1 and not taken, or non-jump two-byte: pc_inc=1 to skip the second byte.
  - In all accepted cases: instr_count+1, next state FETCH.
- Stall: exec_ready=0 holds EXEC. exec_valid stays 1; pc_inc, pc_load and fetch_en stay 0. instr, operand and program_byte are therefore stable.
- pc_inc and pc_load are never high in the same cycle. pc_value=0 whenever pc_load=0.
- Jump to the current instruction's own address is legal and loops.
- PC wrap-around 0xFFF→0x000 is a normal increment, handled by the counter; the sequencer takes no special action.
- A two-byte instruction at 0xFFF takes its second byte from 0x000.
- instr_count wraps 0xFFFF→0x0000.
- Reset asserted mid-EXEC, including during a stall, aborts the instruction: no count and no PC action that cycle.
- Timing: unstalled one-byte instruction = 2 cycles; two-byte = 2 cycles; taken jump = 2 cycles, and the target is fetched on the next FETCH.

Optional Feature:
- Macro: FETCH_SEQ_HALT_EN.
- Defined:
  - In EXEC, HALT_OP accepted with exec_ready=1 → state HALT, instr_count+1.
  - In HALT, all control outputs are 0 and the PC holds.
  - resume=1 → FETCH next edge.
  - reset has priority over resume.
- Undefined:
  - HALT_OP is an ordinary one-byte instruction.
  - The HALT encoding is never produced.
  - resume is ignored.

Test Plan:
- Reset then free-run, ROM[0]=0x8A, ROM[1]=0x9B, exec_ready=1 → state toggles FETCH/EXEC; exec_valid on cycles 2 and 4; instr_count=2 after 4 cycles; pc_load never 1.
- ROM[0]=0x01, ROM[1]=0x23, exec_ready=1 → in EXEC pc_load=1, pc_value=0x123, pc_inc=0; next fetch is from 0x123.
- ROM[0]=0x31, ROM[1]=0x00, zero=0 → not taken: pc_inc=1 in EXEC; next fetch is from address 2; exec_imm=0x00.
- One-byte instruction with exec_ready low for 3 cycles → EXEC held 4 cycles; fetch_en, pc_inc and pc_load stay 0; instr_count increments only on the accept cycle.
- reset pulsed during a stalled EXEC → next cycle state=FETCH, instr_count=0, no pc_load.
- FETCH_SEQ_HALT_EN defined, ROM[0]=0xF0 → state=HALT after accept; PC frozen for 10 cycles; resume=1 → FETCH from address 1.
